subtractor_ternary_serial: RTL and testbench

Multi-cycle ternary subtractor that computes in0 - in1 - in2, modulo 2^WIDTH, digit-serially LSB-first. It is the inverse counterpart of the ternary adder in the arithmetic/addition cookbook. It trades latency for area: one narrow subtract-with-borrow slice is reused across WIDTH/BITS_PER_CYCLE cycles. Valid/ready handshakes on both sides let it sit directly in a streaming datapath.

---
 rtl/subtractor_ternary_serial_if.sv | 25 ++
 rtl/subtractor_ternary_serial.sv | 111 +++++++++++
 tb/tb_subtractor_ternary_serial.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/subtractor_ternary_serial_if.sv
// Valid/ready bundle for the serial ternary subtractor: operand side and result side.
// The slave modport is the subtractor's view; master is the upstream/downstream view.
interface subtractor_ternary_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic [1:0]       borrow;

    modport master (
        output in_valid, in0, in1, in2, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, in0, in1, in2, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/subtractor_ternary_serial.sv
// Digit-serial in0 - in1 - in2 (mod 2^WIDTH), LSB-first, BITS_PER_CYCLE bits per RUN cycle.
// Reports the final borrow (0..2) so the true difference is diff - borrow * 2^WIDTH.
module subtractor_ternary_serial #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic                       clk,
    input logic                       rst,
    subtractor_ternary_serial_if.slave bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("subtractor_ternary_serial: BITS_PER_CYCLE must divide WIDTH and WIDTH >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          a_sr, b_sr, c_sr;
    logic [WIDTH-1:0]          diff_q;
    logic [1:0]                br;
    logic [1:0]                borrow_q;
    logic [CNT_W-1:0]          cnt;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [BITS_PER_CYCLE-1:0] res_chunk;
    logic [1:0]                br_next;

    // Borrow-chain slice: per bit t = a - b - c - br in [-4, 1], next borrow = -floor(t/2).
    always_comb begin
        logic signed [3:0] t;
        logic [1:0]        br_chain;
        // NOTE: blocking assignments are intentional here; the borrow ripples bit to bit
        // within a single evaluation, and every variable gets a default so no latch forms.
        t         = '0;
        br_chain  = br;
        res_chunk = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            t            = 4'({3'b000, a_sr[i]} - {3'b000, b_sr[i]} - {3'b000, c_sr[i]} - {2'b00, br_chain});
            res_chunk[i] = t[0];
            br_chain     = 2'(-(t >>> 1));
        end
        br_next = br_chain;
    end

    // NOTE: sequential state uses non-blocking assignments only; the operand registers
    // are reset too, so an operation discarded by reset leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            c_sr        <= '0;
            diff_q      <= '0;
            br          <= '0;
            borrow_q    <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr       <= bus.in0;
                        b_sr       <= bus.in1;
                        c_sr       <= bus.in2;
                        br         <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> BITS_PER_CYCLE;
                    b_sr   <= b_sr >> BITS_PER_CYCLE;
                    c_sr   <= c_sr >> BITS_PER_CYCLE;
                    // Result chunks enter at the MSB end so the LSB chunk lands at bit 0 last.
                    diff_q <= WIDTH'({res_chunk, diff_q} >> BITS_PER_CYCLE);
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        borrow_q    <= br_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_subtractor_ternary_serial.sv
// Self-checking bench: directed cases, backpressure, reset and random traffic on
// WIDTH=8 instances with BITS_PER_CYCLE=1 and BITS_PER_CYCLE=4.
module tb_subtractor_ternary_serial;
    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    subtractor_ternary_serial_if #(.WIDTH(8)) bus8 ();
    subtractor_ternary_serial_if #(.WIDTH(8)) bus4 ();

    subtractor_ternary_serial #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8.slave)
    );

    subtractor_ternary_serial #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4.slave)
    );

    // Reference: true difference, then fold into [0,255] counting how many 256s were added.
    function automatic logic [9:0] model(input int a, input int b, input int c);
        int t;
        int q;
        t = a - b - c;
        q = 0;
        while (t < 0) begin
            t += 256;
            q++;
        end
        return {2'(q), 8'(t)};
    endfunction

    task automatic check_idle(input virtual subtractor_ternary_serial_if #(.WIDTH(8)) vif,
                              input string name, input logic clear_expected);
        checks++;
        if (vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, vif.in_ready);
        end
        checks++;
        if (vif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid: got %b want 0", name, vif.out_valid);
        end
        if (clear_expected) begin
            checks++;
            if ({vif.borrow, vif.diff} !== 10'd0) begin
                errors++;
                $display("FAIL %s cleared outputs: got borrow=%0d diff=%0d want 0/0",
                         name, vif.borrow, vif.diff);
            end
        end
    endtask

    task automatic run_op(input virtual subtractor_ternary_serial_if #(.WIDTH(8)) vif,
                          input int lat, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [9:0] expv, input string name);
        int k;
        checks++;
        if (vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b want 1", name, vif.in_ready);
        end
        vif.in0      = a;
        vif.in1      = b;
        vif.in2      = c;
        vif.in_valid = 1'b1;
        @(negedge clk);
        vif.in_valid = 1'b0;
        vif.in0      = 8'($urandom);
        vif.in1      = 8'($urandom);
        vif.in2      = 8'($urandom);
        k = 0;
        while (vif.out_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, k, lat);
        end
        checks++;
        if ({vif.borrow, vif.diff} !== expv) begin
            errors++;
            $display("FAIL %s result: got borrow=%0d diff=%0d want borrow=%0d diff=%0d",
                     name, vif.borrow, vif.diff, expv[9:8], expv[7:0]);
        end
    endtask

    task automatic retire(input virtual subtractor_ternary_serial_if #(.WIDTH(8)) vif,
                          input string name);
        vif.out_ready = 1'b1;
        @(negedge clk);
        vif.out_ready = 1'b0;
        check_idle(vif, name, 1'b0);
    endtask

    task automatic test_reset();
        rst8 = 1'b1;
        rst4 = 1'b1;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.in0 = '0; bus8.in1 = '0; bus8.in2 = '0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus4.in0 = '0; bus4.in1 = '0; bus4.in2 = '0;
        repeat (3) @(negedge clk);
        check_idle(bus8, "reset_bpc1", 1'b1);
        check_idle(bus4, "reset_bpc4", 1'b1);
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(bus8, 8, 8'd100, 8'd20, 8'd30, {2'd0, 8'd50}, "basic");
        retire(bus8, "basic_retire");
        run_op(bus8, 8, 8'd5, 8'd10, 8'd20, {2'd1, 8'd231}, "underflow");
        retire(bus8, "underflow_retire");
        run_op(bus8, 8, 8'd0, 8'd255, 8'd255, {2'd2, 8'd2}, "max_borrow");
        retire(bus8, "max_borrow_retire");
        run_op(bus8, 8, 8'd255, 8'd0, 8'd0, {2'd0, 8'd255}, "no_subtrahend");
        retire(bus8, "no_subtrahend_retire");
    endtask

    task automatic test_backpressure();
        run_op(bus8, 8, 8'd77, 8'd3, 8'd4, {2'd0, 8'd70}, "bp_op");
        for (int i = 0; i < 20; i++) begin
            bus8.in_valid = (i == 5);
            bus8.in0 = 8'd9; bus8.in1 = 8'd1; bus8.in2 = 8'd1;
            @(negedge clk);
            checks++;
            if ({bus8.borrow, bus8.diff} !== {2'd0, 8'd70} || bus8.out_valid !== 1'b1
                || bus8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got v=%b r=%b borrow=%0d diff=%0d want v=1 r=0 borrow=0 diff=70",
                         i, bus8.out_valid, bus8.in_ready, bus8.borrow, bus8.diff);
            end
        end
        bus8.in_valid = 1'b0;
        retire(bus8, "bp_retire");
        repeat (12) @(negedge clk);
        check_idle(bus8, "bp_pulse_ignored", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bus8.in0 = 8'd50; bus8.in1 = 8'd1; bus8.in2 = 8'd1;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check_idle(bus8, "mid_run_reset", 1'b1);
        repeat (12) @(negedge clk);
        check_idle(bus8, "mid_run_no_result", 1'b1);
        // Reset and a valid operand arriving together: reset wins.
        rst8 = 1'b1;
        bus8.in0 = 8'd9; bus8.in1 = 8'd2; bus8.in2 = 8'd3;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        bus8.in_valid = 1'b0;
        check_idle(bus8, "rst_and_valid", 1'b1);
        repeat (12) @(negedge clk);
        check_idle(bus8, "rst_and_valid_not_taken", 1'b1);
        run_op(bus8, 8, 8'd200, 8'd1, 8'd1, {2'd0, 8'd198}, "after_reset");
        retire(bus8, "after_reset_retire");
    endtask

    task automatic test_bpc4();
        run_op(bus4, 2, 8'h10, 8'h01, 8'h20, {2'd1, 8'hEF}, "bpc4_basic");
        retire(bus4, "bpc4_retire");
        run_op(bus4, 2, 8'd0, 8'd255, 8'd255, {2'd2, 8'd2}, "bpc4_max_borrow");
        retire(bus4, "bpc4_max_retire");
    endtask

    task automatic test_random(input virtual subtractor_ternary_serial_if #(.WIDTH(8)) vif,
                               input int nops, input string name);
        logic [9:0] q[$];
        logic [9:0] e;
        logic [7:0] a, b, c;
        int sent, got, cyc;
        bit hold;
        sent = 0; got = 0; cyc = 0; hold = 1'b0;
        a = '0; b = '0; c = '0;
        vif.in_valid  = 1'b0;
        vif.out_ready = 1'b0;
        @(negedge clk);
        while (got < nops && cyc < 40 * nops) begin
            vif.out_ready = 1'($urandom_range(0, 1));
            if (vif.out_valid === 1'b1 && vif.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s duplicate: result borrow=%0d diff=%0d with no pending operation",
                             name, vif.borrow, vif.diff);
                end else begin
                    e = q.pop_front();
                    if ({vif.borrow, vif.diff} !== e) begin
                        errors++;
                        $display("FAIL %s op %0d: got borrow=%0d diff=%0d want borrow=%0d diff=%0d",
                                 name, got, vif.borrow, vif.diff, e[9:8], e[7:0]);
                    end
                end
                got++;
            end
            if (!hold) begin
                if (sent < nops && $urandom_range(0, 1) == 1) begin
                    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
                    vif.in0 = a; vif.in1 = b; vif.in2 = c;
                    vif.in_valid = 1'b1;
                end else begin
                    vif.in_valid = 1'b0;
                    vif.in0 = 8'($urandom);
                end
            end
            if (vif.in_valid && vif.in_ready === 1'b1) begin
                q.push_back(model(int'(a), int'(b), int'(c)));
                sent++;
                hold = 1'b0;
            end else begin
                hold = vif.in_valid;
            end
            @(negedge clk);
            cyc++;
        end
        vif.in_valid  = 1'b0;
        vif.out_ready = 1'b0;
        checks++;
        if (got !== nops || q.size() != 0) begin
            errors++;
            $display("FAIL %s completion: got %0d results, %0d pending, want %0d results, 0 pending",
                     name, got, q.size(), nops);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_bpc4();
        test_random(bus8, 2000, "random_bpc1");
        test_random(bus4, 1000, "random_bpc4");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
